// File: rtl/pred_result_store_if.sv
// Bundle between the classifier wrapper / host and the prediction store.
//
// Parameters: PRED_BITS (one prediction width) and BRAM_ADDR_BITS (memory address width).
// They must match the pred_result_store instance they connect to.
//
// Signals:
//   wr_addr, wr_data, wr_we : prediction write port (wrapper -> store)
//   rd_en, rd_addr          : host read request (host -> store)
//   rd_data, rd_valid       : registered read response, one cycle after rd_en
//   clear                   : pulse that starts a memory and counter clear
//   busy                    : clear sweep in progress
//   wr_count, wr_drop       : saturating accepted-write count and sticky drop flag
//   hist                    : per-class counters, class k at [k*(BRAM_ADDR_BITS+1) +: BRAM_ADDR_BITS+1]
// Modports: master drives requests, slave (the store) drives responses and status.
interface pred_result_store_if #(
  parameter int unsigned PRED_BITS      = 2,
  parameter int unsigned BRAM_ADDR_BITS = 14
);
  localparam int unsigned CntW  = BRAM_ADDR_BITS + 1;
  localparam int unsigned HistW = (2 ** PRED_BITS) * CntW;

  logic [BRAM_ADDR_BITS-1:0] wr_addr;
  logic [PRED_BITS-1:0]      wr_data;
  logic                      wr_we;
  logic                      rd_en;
  logic [BRAM_ADDR_BITS-1:0] rd_addr;
  logic [PRED_BITS-1:0]      rd_data;
  logic                      rd_valid;
  logic                      clear;
  logic                      busy;
  logic [CntW-1:0]           wr_count;
  logic                      wr_drop;
  logic [HistW-1:0]          hist;

  modport master (
    output wr_addr, wr_data, wr_we, rd_en, rd_addr, clear,
    input  rd_data, rd_valid, busy, wr_count, wr_drop, hist
  );

  modport slave (
    input  wr_addr, wr_data, wr_we, rd_en, rd_addr, clear,
    output rd_data, rd_valid, busy, wr_count, wr_drop, hist
  );
endinterface

// File: rtl/pred_result_store.sv
// Prediction result store: a simple-dual-port RAM holding one classifier prediction per
// address, a saturating accepted-write counter, optional per-class histogram counters, and a
// clear sweep that zeroes the whole memory one address per cycle.
//
// Ports:
//   ap_clk   : clock, rising edge
//   ap_rst_n : asynchronous active-low reset (memory contents are not reset)
//   bus      : pred_result_store_if.slave (write port, read port, clear/busy, status, hist)
//
// Optional feature: define PRED_RESULT_STORE_HIST_EN to build the per-class hist counters;
// without it hist is tied to zero and no class counters exist.
module pred_result_store #(
  parameter int unsigned PRED_BITS      = 2,
  parameter int unsigned BRAM_ADDR_BITS = 14
) (
  input logic               ap_clk,
  input logic               ap_rst_n,
  pred_result_store_if.slave bus
);

  localparam int unsigned Depth      = 2 ** BRAM_ADDR_BITS;
  localparam int unsigned CntW       = BRAM_ADDR_BITS + 1;
  localparam int unsigned NumClasses = 2 ** PRED_BITS;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                    r_state;
  state_e                    w_state_d;
  logic [BRAM_ADDR_BITS-1:0] r_ptr;
  logic [PRED_BITS-1:0]      r_mem [Depth];
  logic [PRED_BITS-1:0]      r_rd_data;
  logic                      r_rd_valid;
  logic [CntW-1:0]           r_wr_count;
  logic                      r_wr_drop;

  logic                      w_start;
  logic                      w_wr_ok;
  logic                      w_rd_ok;
  logic                      w_drop;
  logic                      w_mem_we;
  logic [BRAM_ADDR_BITS-1:0] w_mem_addr;
  logic [PRED_BITS-1:0]      w_mem_din;

  // A clear pulse wins over a coincident write; the write is counted as dropped.
  assign w_start = (r_state == StIdle) && bus.clear;
  assign w_wr_ok = (r_state == StIdle) && bus.wr_we && !bus.clear;
  assign w_rd_ok = (r_state == StIdle) && bus.rd_en;
  assign w_drop  = bus.wr_we && ((r_state == StClear) || bus.clear);

  // Single write port shared between the sweep and normal writes.
  assign w_mem_we   = (r_state == StClear) || w_wr_ok;
  assign w_mem_addr = (r_state == StClear) ? r_ptr : bus.wr_addr;
  assign w_mem_din  = (r_state == StClear) ? '0 : bus.wr_data;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (bus.clear) w_state_d = StClear;
      StClear: if (r_ptr == BRAM_ADDR_BITS'(Depth - 1)) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= StIdle;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_start) begin
        r_ptr <= '0;
      end else if (r_state == StClear) begin
        r_ptr <= r_ptr + BRAM_ADDR_BITS'(1);
      end
    end
  end

  // Memory array has no reset so it maps onto block RAM; read-first by nonblocking order.
  always_ff @(posedge ap_clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_din;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_ok;
      if (w_rd_ok) begin
        r_rd_data <= r_mem[bus.rd_addr];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_wr_count <= '0;
      r_wr_drop  <= 1'b0;
    end else begin
      if (w_start) begin
        r_wr_count <= '0;
      end else if (w_wr_ok && (r_wr_count != '1)) begin
        r_wr_count <= r_wr_count + CntW'(1);
      end
      if (w_start) begin
        r_wr_drop <= bus.wr_we;
      end else if (w_drop) begin
        r_wr_drop <= 1'b1;
      end
    end
  end

`ifdef PRED_RESULT_STORE_HIST_EN
  logic [CntW-1:0] r_hist [NumClasses];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int unsigned k = 0; k < NumClasses; k++) r_hist[k] <= '0;
    end else if (w_start) begin
      for (int unsigned k = 0; k < NumClasses; k++) r_hist[k] <= '0;
    end else if (w_wr_ok && (r_hist[bus.wr_data] != '1)) begin
      r_hist[bus.wr_data] <= r_hist[bus.wr_data] + CntW'(1);
    end
  end

  for (genvar k = 0; k < NumClasses; k++) begin : g_hist
    assign bus.hist[k*CntW +: CntW] = r_hist[k];
  end
`else
  assign bus.hist = '0;
`endif

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.busy     = (r_state == StClear);
  assign bus.wr_count = r_wr_count;
  assign bus.wr_drop  = r_wr_drop;

endmodule

// File: tb/tb_pred_result_store.sv
module tb_pred_result_store;
  localparam int unsigned PB = 2;
  localparam int unsigned AB = 4;
  localparam int unsigned CW = AB + 1;
  localparam int unsigned NC = 1 << PB;
`ifdef PRED_RESULT_STORE_HIST_EN
  localparam bit HistOn = 1'b1;
`else
  localparam bit HistOn = 1'b0;
`endif

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  pred_result_store_if #(.PRED_BITS(PB), .BRAM_ADDR_BITS(AB)) bus ();

  pred_result_store #(.PRED_BITS(PB), .BRAM_ADDR_BITS(AB)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  typedef struct {
    logic          we;
    logic [AB-1:0] wa;
    logic [PB-1:0] wd;
    logic          re;
    logic [AB-1:0] ra;
    logic [PB-1:0] rd_exp;
  } vec_t;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [PB-1:0] exp_q[$];
  logic [PB-1:0] e_rd;
  vec_t          vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] hist_k(input int k);
    return bus.hist[k*CW +: CW];
  endfunction

  // Scoreboard: every returned read is compared against the oldest pushed expectation.
  always @(posedge ap_clk) begin
    #1;
    if (bus.rd_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected: rd_valid=1 data %0h, required no response", bus.rd_data);
      end else begin
        e_rd = exp_q.pop_front();
        check("rd_data", 32'(bus.rd_data), 32'(e_rd));
      end
    end
  end

  task automatic idle_inputs();
    bus.wr_we   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    bus.clear   = 1'b0;
  endtask

  // Called at a negedge; drives one cycle and checks read latency at the next negedge.
  task automatic apply(input vec_t v);
    bus.wr_we   = v.we;
    bus.wr_addr = v.wa;
    bus.wr_data = v.wd;
    bus.rd_en   = v.re;
    bus.rd_addr = v.ra;
    if (v.re) exp_q.push_back(v.rd_exp);
    @(negedge ap_clk);
    check("rd_valid_latency", 32'(bus.rd_valid), 32'(v.re));
    idle_inputs();
  endtask

  task automatic read_exp(input logic [AB-1:0] a, input logic [PB-1:0] d);
    vec_t v;
    v = '{we: 1'b0, wa: '0, wd: '0, re: 1'b1, ra: a, rd_exp: d};
    apply(v);
  endtask

  task automatic write_one(input logic [AB-1:0] a, input logic [PB-1:0] d);
    vec_t v;
    v = '{we: 1'b1, wa: a, wd: d, re: 1'b0, ra: '0, rd_exp: '0};
    apply(v);
  endtask

  task automatic sweep(input bit with_we, input bit inject);
    int cnt;
    bus.clear   = 1'b1;
    bus.wr_we   = with_we;
    bus.wr_addr = 4'd9;
    bus.wr_data = 2'd3;
    @(negedge ap_clk);
    idle_inputs();
    cnt = 0;
    while (bus.busy && cnt < 64) begin
      if (inject && cnt == 3) begin
        bus.wr_we   = 1'b1;
        bus.wr_addr = 4'd10;
        bus.wr_data = 2'd2;
        bus.rd_en   = 1'b1;
        bus.rd_addr = 4'd9;
        bus.clear   = 1'b1;
      end else begin
        idle_inputs();
      end
      cnt++;
      @(negedge ap_clk);
      if (inject && cnt == 4) begin
        check("rd_valid_during_busy", 32'(bus.rd_valid), 32'd0);
        check("wr_drop_during_busy", 32'(bus.wr_drop), 32'd1);
      end
    end
    idle_inputs();
    check("busy_cycles", 32'(cnt), 32'd16);
  endtask

  initial begin
    idle_inputs();
    vecs[0] = '{we: 1, wa: 3, wd: 2, re: 0, ra: 0, rd_exp: 0};
    vecs[1] = '{we: 1, wa: 5, wd: 1, re: 0, ra: 0, rd_exp: 0};
    vecs[2] = '{we: 0, wa: 0, wd: 0, re: 1, ra: 3, rd_exp: 2};
    vecs[3] = '{we: 0, wa: 0, wd: 0, re: 1, ra: 5, rd_exp: 1};
    vecs[4] = '{we: 1, wa: 7, wd: 1, re: 0, ra: 0, rd_exp: 0};
    vecs[5] = '{we: 1, wa: 7, wd: 3, re: 1, ra: 7, rd_exp: 1};
    vecs[6] = '{we: 0, wa: 0, wd: 0, re: 1, ra: 7, rd_exp: 3};
    vecs[7] = '{we: 0, wa: 0, wd: 0, re: 1, ra: 0, rd_exp: 0};
    vecs[8] = '{we: 1, wa: 3, wd: 0, re: 1, ra: 3, rd_exp: 2};
    vecs[9] = '{we: 0, wa: 0, wd: 0, re: 1, ra: 5, rd_exp: 1};

    repeat (2) @(negedge ap_clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_wr_count", 32'(bus.wr_count), 32'd0);
    check("rst_wr_drop", 32'(bus.wr_drop), 32'd0);
    check("rst_hist", 32'(bus.hist), 32'd0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    sweep(1'b0, 1'b0);
    check("clr_wr_count", 32'(bus.wr_count), 32'd0);
    check("clr_wr_drop", 32'(bus.wr_drop), 32'd0);
    for (int a = 0; a < 16; a++) read_exp(AB'(a), 2'd0);

    for (int i = 0; i < 10; i++) apply(vecs[i]);
    @(negedge ap_clk);
    check("hold_rd_data", 32'(bus.rd_data), 32'd1);
    check("hold_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("wr_count_5", 32'(bus.wr_count), 32'd5);
    check("hist0", 32'(hist_k(0)), HistOn ? 32'd1 : 32'd0);
    check("hist1", 32'(hist_k(1)), HistOn ? 32'd2 : 32'd0);
    check("hist2", 32'(hist_k(2)), HistOn ? 32'd1 : 32'd0);
    check("hist3", 32'(hist_k(3)), HistOn ? 32'd1 : 32'd0);

    // Clear with a coincident write, plus a write, read and clear while busy.
    sweep(1'b1, 1'b1);
    check("drop_wr_count", 32'(bus.wr_count), 32'd0);
    check("drop_flag", 32'(bus.wr_drop), 32'd1);
    check("drop_hist", 32'(bus.hist), 32'd0);
    read_exp(4'd9, 2'd0);
    read_exp(4'd10, 2'd0);
    read_exp(4'd5, 2'd0);
    check("drop_sticky", 32'(bus.wr_drop), 32'd1);
    sweep(1'b0, 1'b0);
    check("drop_cleared", 32'(bus.wr_drop), 32'd0);

    for (int i = 0; i < 40; i++) write_one(AB'(i), 2'd0);
    check("sat_wr_count", 32'(bus.wr_count), 32'd31);
    check("sat_hist0", 32'(hist_k(0)), HistOn ? 32'd31 : 32'd0);
    check("sat_hist1", 32'(hist_k(1)), 32'd0);
    write_one(4'd2, 2'd3);
    check("sat_hold", 32'(bus.wr_count), 32'd31);
    read_exp(4'd2, 2'd3);
    read_exp(4'd4, 2'd0);
    read_exp(4'd2, 2'd3);

    // Reset 5 cycles into a sweep.
    bus.clear = 1'b1;
    @(negedge ap_clk);
    idle_inputs();
    repeat (4) @(negedge ap_clk);
    check("mid_busy", 32'(bus.busy), 32'd1);
    #2 ap_rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_rd_data", 32'(bus.rd_data), 32'd0);
    check("abort_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("abort_wr_count", 32'(bus.wr_count), 32'd0);
    check("abort_hist", 32'(bus.hist), 32'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (2) @(negedge ap_clk);
    check("post_abort_busy", 32'(bus.busy), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pred_result_store.md
PRED_RESULT_STORE -- requirements
Module: pred_result_store

Interface
REQ-001 SHALL have parameter PRED_BITS, default 2, the width of one classifier prediction.
REQ-002 SHALL have parameter BRAM_ADDR_BITS, default 14, the prediction memory address width; depth is 2^BRAM_ADDR_BITS.
REQ-003 SHALL have port ap_clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-004 SHALL have port ap_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port wr_addr, input, BRAM_ADDR_BITS bits: prediction write address from the classifier wrapper.
REQ-006 SHALL have port wr_data, input, PRED_BITS bits: prediction value.
REQ-007 SHALL have port wr_we, input, 1 bit: write strobe, one cycle per prediction.
REQ-008 SHALL have port rd_en, input, 1 bit: host read request.
REQ-009 SHALL have port rd_addr, input, BRAM_ADDR_BITS bits: host read address.
REQ-010 SHALL have port rd_data, output, PRED_BITS bits: registered read data.
REQ-011 SHALL have port rd_valid, output, 1 bit: rd_data is valid this cycle.
REQ-012 SHALL have port clear, input, 1 bit: single-cycle pulse that starts a memory and counter clear.
REQ-013 SHALL have port busy, output, 1 bit: clear sweep is in progress.
REQ-014 SHALL have port wr_count, output, BRAM_ADDR_BITS+1 bits: number of accepted writes, saturating.
REQ-015 SHALL have port wr_drop, output, 1 bit: sticky flag set when a write is dropped during a sweep.
REQ-016 SHALL have port hist, output, (2^PRED_BITS)*(BRAM_ADDR_BITS+1) bits: per-class counters packed with class k at bits [k*(BRAM_ADDR_BITS+1) +: BRAM_ADDR_BITS+1].

Function
REQ-017 SHALL implement a state machine with two states: IDLE and CLEAR.
REQ-018 SHALL move from IDLE to CLEAR on clear=1, reset the sweep pointer to 0, and zero wr_count, hist and wr_drop on that same edge.
REQ-019 SHALL, in CLEAR, write 0 to memory[ptr] every cycle and increment ptr.
REQ-020 SHALL return to IDLE on the cycle after writing address 2^BRAM_ADDR_BITS-1, so a sweep lasts exactly 2^BRAM_ADDR_BITS cycles.
REQ-021 SHALL drive busy=1 exactly while the state is CLEAR.
REQ-022 SHALL ignore clear while in CLEAR; the sweep is not restarted.
REQ-023 SHALL, in IDLE with wr_we=1, write wr_data to memory[wr_addr] and increment wr_count and hist[wr_data] by 1 each; all counters saturate at all-ones.
REQ-024 SHALL, when wr_we=1 while busy=1, drop the write, leave the counters unchanged and set wr_drop=1.
REQ-025 SHALL, in IDLE with rd_en=1, present memory[rd_addr] on rd_data with rd_valid=1 on the next cycle (latency 1).
REQ-026 SHALL hold rd_data unchanged and drive rd_valid=0 when there is no read.
REQ-027 SHALL ignore rd_en while busy=1: rd_valid stays 0.
REQ-028 SHALL, when a read and a write hit the same address in one cycle, return the old contents (read-first).
REQ-029 SHALL, when clear and wr_we coincide in IDLE, drop the write, enter CLEAR and set wr_drop=1.
REQ-030 SHALL wrap wr_addr naturally; no address checks are made.
REQ-031 SHALL infer the memory as a single simple-dual-port block RAM.

Reset
REQ-032 SHALL, on ap_rst_n=0, put the state in IDLE, ptr=0, rd_data=0, rd_valid=0, busy=0, wr_count=0, wr_drop=0 and all hist counters 0.
REQ-033 SHALL NOT reset memory contents; software issues a clear after power-up.
REQ-034 SHALL abort a sweep when reset is asserted mid-sweep; after reset the state is IDLE and memory is partially cleared.

Configuration
REQ-035 SHALL compile the hist counters in when macro PRED_RESULT_STORE_HIST_EN is defined.
REQ-036 SHALL, without PRED_RESULT_STORE_HIST_EN, tie hist to constant 0 and instantiate no class-counter registers; all other behaviour is unchanged.

Verification (BRAM_ADDR_BITS=4 where noted)
REQ-037 SHALL cover: writes (addr 3, data 2) then (addr 5, data 1), then read addr 3 -> rd_data=2 with rd_valid=1 one cycle after rd_en, wr_count=2, hist[2]=1, hist[1]=1.
REQ-038 SHALL cover, with BRAM_ADDR_BITS=4: clear pulse -> busy=1 for exactly 16 cycles, then reads of every address return 0, and all counters are 0.
REQ-039 SHALL cover: wr_we during busy, and wr_we coinciding with clear -> write not stored, wr_count unchanged, wr_drop=1 until the next clear.
REQ-040 SHALL cover: read and write of addr 7 in the same cycle with old value 1 and new value 3 -> rd_data=1, and a later read returns 3.
REQ-041 SHALL cover, with BRAM_ADDR_BITS=4: 40 writes of class 0 -> hist[0] and wr_count saturate at 31.
REQ-042 SHALL cover: reset asserted 5 cycles into a sweep -> busy=0 and all outputs 0 immediately; with the macro undefined, hist=0 after writes.
